// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port data RAM between port A (rd/wr) and port B (rd).
// Optional: define ARB_FIXED_PRIORITY_EN for fixed A-over-B priority (default round-robin).
module ram_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [ADDRESS_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]    a_wdata,
    output logic                     a_gnt,
    output logic                     a_rvalid,
    output logic [DATA_WIDTH-1:0]    a_rdata,
    input  logic                     b_req,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    output logic                     b_gnt,
    output logic                     b_rvalid,
    output logic [DATA_WIDTH-1:0]    b_rdata,
    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_A    = 2'd1,
        TAG_B    = 2'd2
    } tag_t;

    tag_t                  rd_tag;
    tag_t                  rd_tag_nxt;
    logic [DATA_WIDTH-1:0] a_hold;
    logic [DATA_WIDTH-1:0] a_hold_nxt;
    logic [DATA_WIDTH-1:0] b_hold;
    logic [DATA_WIDTH-1:0] b_hold_nxt;
    logic                  sel_a;
    logic                  sel_b;

`ifdef ARB_FIXED_PRIORITY_EN

    // Fixed priority: A always wins, B only gets idle slots of A
    always_comb begin
        sel_a = a_req;
        sel_b = b_req & ~a_req;
    end

`else

    typedef enum logic {
        WIN_A = 1'b0,
        WIN_B = 1'b1
    } win_t;

    win_t last_winner;
    win_t last_winner_nxt;
    logic conflict;

    assign conflict = a_req & b_req;

    // Round-robin: on a conflict, the loser of the previous conflict wins
    always_comb begin
        sel_a           = 1'b0;
        sel_b           = 1'b0;
        last_winner_nxt = last_winner;
        if (conflict) begin
            if (last_winner == WIN_B) begin
                sel_a           = 1'b1;
                last_winner_nxt = WIN_A;
            end else begin
                sel_b           = 1'b1;
                last_winner_nxt = WIN_B;
            end
        end else if (a_req) begin
            sel_a = 1'b1;
        end else if (b_req) begin
            sel_b = 1'b1;
        end
    end

    // Conflict history; reset to B so A takes the first conflict
    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= WIN_B;
        end else begin
            last_winner <= last_winner_nxt;
        end
    end

`endif

    // Grants are suppressed for the whole time reset is high
    always_comb begin
        a_gnt = sel_a & ~reset;
        b_gnt = sel_b & ~reset;
    end

    // Steer the granted port onto the RAM; idle drives all zeros
    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = '0;
        ram_dataIn = '0;
        unique case (1'b1)
            a_gnt: begin
                ram_wEn    = a_we;
                ram_addr   = a_addr;
                ram_dataIn = a_wdata;
            end
            b_gnt: begin
                ram_addr   = b_addr;
            end
            default: ;
        endcase
    end

    // Tag each granted read so the returning word goes to its issuer
    always_comb begin
        rd_tag_nxt = TAG_NONE;
        if (a_gnt && !a_we) begin
            rd_tag_nxt = TAG_A;
        end else if (b_gnt) begin
            rd_tag_nxt = TAG_B;
        end
    end

    // Return path: live RAM data on the strobe, held copy otherwise
    always_comb begin
        a_rvalid   = (rd_tag == TAG_A);
        b_rvalid   = (rd_tag == TAG_B);
        a_rdata    = a_rvalid ? ram_dataOut : a_hold;
        b_rdata    = b_rvalid ? ram_dataOut : b_hold;
        a_hold_nxt = a_rvalid ? ram_dataOut : a_hold;
        b_hold_nxt = b_rvalid ? ram_dataOut : b_hold;
    end

    // Read tag and per-port hold registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_tag <= TAG_NONE;
            a_hold <= '0;
            b_hold <= '0;
        end else begin
            rd_tag <= rd_tag_nxt;
            a_hold <= a_hold_nxt;
            b_hold <= b_hold_nxt;
        end
    end

endmodule
